// File: rtl/compress_sequencer_if.sv
// Handshake bundle between the compression top level and its block sequencer.
// The top level drives the inputs through the master modport, and the sequencer drives the strobes through the slave modport.
interface compress_sequencer_if;
  logic        iEnable;
  logic        iValid;
  logic        iDurbinDone;
  logic        oAcfReset;
  logic        oAcfEnable;
  logic        oModelStart;
  logic        oModelEnable;
  logic        oBankReset;
  logic        oBankValid;
  logic        oCoeffUnload;
  logic        oResidualValid;
  logic        oFrameStart;
  logic [15:0] oFrameCount;
  logic        oOverrun;

  modport master (
    output iEnable, iValid, iDurbinDone,
    input  oAcfReset, oAcfEnable, oModelStart, oModelEnable, oBankReset,
           oBankValid, oCoeffUnload, oResidualValid, oFrameStart,
           oFrameCount, oOverrun
  );

  modport slave (
    input  iEnable, iValid, iDurbinDone,
    output oAcfReset, oAcfEnable, oModelStart, oModelEnable, oBankReset,
           oBankValid, oCoeffUnload, oResidualValid, oFrameStart,
           oFrameCount, oOverrun
  );
endinterface

// File: rtl/compress_sequencer.sv
// Block scheduler for the ACF -> model -> bank -> residual pipeline.
// Define SEQ_WATCHDOG_EN to build in the Durbin solve watchdog (MODEL_CYCLES limit).
module compress_sequencer #(
  parameter int BLOCK_SIZE   = 4096,
  parameter int COPY_CYCLES  = 12,
  parameter int MODEL_CYCLES = 1152
) (
  input  logic iClock,
  input  logic iReset,
  compress_sequencer_if.slave bus
);

  localparam int IDX_W = $clog2(BLOCK_SIZE);
  localparam int CC_W  = $clog2(COPY_CYCLES) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_SIZE - 1);

  generate
    if (BLOCK_SIZE < 16 || (BLOCK_SIZE & (BLOCK_SIZE - 1)) != 0) begin : g_bad_block
      $error("BLOCK_SIZE must be a power of two and at least 16");
    end
    if (COPY_CYCLES < 1 || COPY_CYCLES + MODEL_CYCLES >= BLOCK_SIZE) begin : g_bad_timing
      $error("COPY_CYCLES + MODEL_CYCLES must fit inside one block");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_COPY, S_SOLVE, S_READY} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [IDX_W-1:0]  r_idx;
  logic [CC_W-1:0]   r_copy_cnt;
  logic              r_vb;
  logic              r_vr;
  logic              w_acc;
  logic              w_bnd;
  logic              w_first;
  logic              w_overrun_set;
  logic              w_wd_expired;

  logic              r_acf_reset;
  logic              r_acf_en;
  logic              r_model_start;
  logic              r_model_en;
  logic              r_bank_reset;
  logic              r_bank_valid;
  logic              r_coeff_unload;
  logic              r_res_valid;
  logic              r_frame_start;
  logic [15:0]       r_frame_cnt;
  logic              r_overrun;

  assign w_acc   = bus.iValid & bus.iEnable;
  assign w_bnd   = w_acc & (r_idx == LAST_IDX);
  assign w_first = w_acc & (r_idx == '0);

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      r_idx <= '0;
    end else if (w_acc) begin
      r_idx <= r_idx + IDX_W'(1);
    end
  end

`ifdef SEQ_WATCHDOG_EN
  localparam int WD_W = $clog2(MODEL_CYCLES) + 1;
  logic [WD_W-1:0] r_wd_cnt;

  // Counts solve cycles only; leaving SOLVE rearms it for the next block.
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      r_wd_cnt <= '0;
    end else if (r_state != S_SOLVE) begin
      r_wd_cnt <= '0;
    end else if (bus.iEnable) begin
      r_wd_cnt <= r_wd_cnt + WD_W'(1);
    end
  end

  assign w_wd_expired = (r_state == S_SOLVE) && (r_wd_cnt == WD_W'(MODEL_CYCLES - 1));
`else
  assign w_wd_expired = 1'b0;
`endif

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A block boundary always restarts the model for the block just finished.
  always_comb begin
    w_state_nxt   = r_state;
    w_overrun_set = 1'b0;
    if (w_bnd) begin
      w_state_nxt   = S_COPY;
      w_overrun_set = (r_state == S_COPY) || (r_state == S_SOLVE);
    end else if (bus.iEnable) begin
      case (r_state)
        S_COPY: begin
          if (r_copy_cnt == '0) begin
            w_state_nxt = S_SOLVE;
          end
        end
        S_SOLVE: begin
          if (bus.iDurbinDone) begin
            w_state_nxt = S_READY;
          end else if (w_wd_expired) begin
            w_state_nxt   = S_IDLE;
            w_overrun_set = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      r_copy_cnt <= '0;
    end else if (w_bnd) begin
      r_copy_cnt <= CC_W'(COPY_CYCLES - 1);
    end else if (bus.iEnable && r_state == S_COPY && r_copy_cnt != '0) begin
      r_copy_cnt <= r_copy_cnt - CC_W'(1);
    end
  end

  // An aborted or unfinished model hands a zero token to the bank stage.
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      r_vb <= 1'b0;
      r_vr <= 1'b0;
    end else if (w_bnd) begin
      r_vb <= (r_state == S_READY);
      r_vr <= r_vb;
    end
  end

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      r_acf_reset    <= 1'b0;
      r_acf_en       <= 1'b0;
      r_model_start  <= 1'b0;
      r_model_en     <= 1'b0;
      r_bank_reset   <= 1'b0;
      r_bank_valid   <= 1'b0;
      r_coeff_unload <= 1'b0;
      r_res_valid    <= 1'b0;
      r_frame_start  <= 1'b0;
      r_frame_cnt    <= '0;
      r_overrun      <= 1'b0;
    end else begin
      r_acf_reset    <= w_first;
      r_acf_en       <= w_acc;
      r_model_start  <= w_bnd;
      r_model_en     <= (w_state_nxt == S_COPY) || (w_state_nxt == S_SOLVE);
      r_bank_reset   <= w_bnd & (r_state == S_READY);
      r_bank_valid   <= w_acc & r_vb;
      r_coeff_unload <= w_bnd & r_vb;
      r_res_valid    <= w_acc & r_vr;
      r_frame_start  <= w_first & r_vr;
      if (w_bnd && r_vr) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
      if (w_overrun_set) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign bus.oAcfReset      = r_acf_reset;
  assign bus.oAcfEnable     = r_acf_en;
  assign bus.oModelStart    = r_model_start;
  assign bus.oModelEnable   = r_model_en;
  assign bus.oBankReset     = r_bank_reset;
  assign bus.oBankValid     = r_bank_valid;
  assign bus.oCoeffUnload   = r_coeff_unload;
  assign bus.oResidualValid = r_res_valid;
  assign bus.oFrameStart    = r_frame_start;
  assign bus.oFrameCount    = r_frame_cnt;
  assign bus.oOverrun       = r_overrun;

endmodule

// File: tb/tb_compress_sequencer.sv
// Directed bench for compress_sequencer with BLOCK_SIZE=16, COPY_CYCLES=2, MODEL_CYCLES=6.
// Output vector order: AcfReset AcfEnable ModelStart ModelEnable BankReset BankValid CoeffUnload ResidualValid FrameStart Overrun.
module tb_compress_sequencer;
  logic iClock = 1'b0;
  logic iReset = 1'b1;
  int   checks   = 0;
  int   failures = 0;

`ifdef SEQ_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  compress_sequencer_if bus();

  compress_sequencer #(
    .BLOCK_SIZE  (16),
    .COPY_CYCLES (2),
    .MODEL_CYCLES(6)
  ) dut (
    .iClock(iClock),
    .iReset(iReset),
    .bus   (bus)
  );

  always #5 iClock = ~iClock;

  function automatic logic [9:0] obs();
    return {bus.oAcfReset, bus.oAcfEnable, bus.oModelStart, bus.oModelEnable,
            bus.oBankReset, bus.oBankValid, bus.oCoeffUnload, bus.oResidualValid,
            bus.oFrameStart, bus.oOverrun};
  endfunction

  task automatic step(input logic en, input logic v, input logic d);
    @(negedge iClock);
    bus.iEnable     = en;
    bus.iValid      = v;
    bus.iDurbinDone = d;
    @(posedge iClock);
    #1;
  endtask

  task automatic test_reset();
    bus.iEnable = 1'b1; bus.iValid = 1'b1; bus.iDurbinDone = 1'b0;
    #3;
    checks++;
    if (obs() !== 10'b0 || bus.oFrameCount !== 16'h0) begin
      failures++;
      $display("FAIL reset_initial got=%b/%h exp=0/0000", obs(), bus.oFrameCount);
    end
    repeat (2) @(posedge iClock);
    #1;
    checks++;
    if (obs() !== 10'b0 || bus.oFrameCount !== 16'h0) begin
      failures++;
      $display("FAIL reset_held got=%b/%h exp=0/0000", obs(), bus.oFrameCount);
    end
    @(negedge iClock);
    bus.iValid = 1'b0;
    iReset = 1'b0;
  endtask

  task automatic test_pipeline();
    logic [9:0]  exp;
    logic [15:0] exp_fc;
    for (int k = 0; k < 64; k++) begin
      int off;
      off = k % 16;
      step(1'b1, 1'b1, off == 4);
      exp = {off == 0, 1'b1, off == 15, (k >= 15) && (off == 15 || off <= 3),
             (k == 31 || k == 47 || k == 63), k >= 32, (k == 47 || k == 63),
             k >= 48, k == 48, 1'b0};
      exp_fc = (k >= 63) ? 16'd1 : 16'd0;
      checks++;
      if (obs() !== exp || bus.oFrameCount !== exp_fc) begin
        failures++;
        $display("FAIL pipeline k=%0d got=%b/%0d exp=%b/%0d", k, obs(), bus.oFrameCount, exp, exp_fc);
      end
    end
  endtask

  task automatic test_overrun();
    logic [9:0]  exp;
    logic [15:0] exp_fc;
    for (int k = 64; k < 96; k++) begin
      int off;
      off = k % 16;
      step(1'b1, 1'b1, (k >= 80) && (off == 4));
      exp = {off == 0, 1'b1, off == 15,
             (k < 80) ? (k == 79 || !WD || k <= 70) : (off <= 3 || off == 15),
             k == 95, k < 80, k == 79, 1'b1, (k == 64 || k == 80),
             WD ? (k >= 71) : (k >= 79)};
      exp_fc = (k >= 95) ? 16'd3 : ((k >= 79) ? 16'd2 : 16'd1);
      checks++;
      if (obs() !== exp || bus.oFrameCount !== exp_fc) begin
        failures++;
        $display("FAIL overrun k=%0d got=%b/%0d exp=%b/%0d", k, obs(), bus.oFrameCount, exp, exp_fc);
      end
    end
  endtask

  task automatic test_enable_hold();
    logic [9:0] exp;
    for (int k = 96; k < 112; k++) begin
      int off;
      off = k % 16;
      if (k == 104) begin
        for (int c = 0; c < 5; c++) begin
          step(1'b0, 1'b1, 1'b0);
          checks++;
          if (obs() !== 10'b00_0000_0001 || bus.oFrameCount !== 16'd3) begin
            failures++;
            $display("FAIL enable_low c=%0d got=%b/%0d exp=0000000001/3", c, obs(), bus.oFrameCount);
          end
        end
      end
      step(1'b1, 1'b1, k == 100);
      exp = {off == 0, 1'b1, off == 15, (off <= 3 || off == 15), off == 15,
             1'b1, off == 15, 1'b0, 1'b0, 1'b1};
      checks++;
      if (obs() !== exp || bus.oFrameCount !== 16'd3) begin
        failures++;
        $display("FAIL enable_resume k=%0d got=%b/%0d exp=%b/3", k, obs(), bus.oFrameCount, exp);
      end
    end
  endtask

  task automatic test_async_reset();
    for (int k = 112; k < 117; k++) begin
      step(1'b1, 1'b1, 1'b0);
    end
    checks++;
    if (bus.oModelEnable !== 1'b1 || bus.oOverrun !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_solve got=%b%b exp=11", bus.oModelEnable, bus.oOverrun);
    end
    #2;
    iReset = 1'b1;
    #1;
    checks++;
    if (obs() !== 10'b0 || bus.oFrameCount !== 16'h0) begin
      failures++;
      $display("FAIL async_reset got=%b/%0d exp=0/0", obs(), bus.oFrameCount);
    end
    @(negedge iClock);
    bus.iValid = 1'b0;
    @(negedge iClock);
    iReset = 1'b0;
    step(1'b1, 1'b1, 1'b0);
    checks++;
    if (obs() !== 10'b11_0000_0000) begin
      failures++;
      $display("FAIL first_after_reset got=%b exp=1100000000", obs());
    end
  endtask

  task automatic test_frame_wrap();
    @(negedge iClock);
    bus.iValid = 1'b0;
    iReset = 1'b1;
    @(negedge iClock);
    iReset = 1'b0;
    force dut.r_frame_cnt = 16'hFFFF;
    @(posedge iClock);
    #1;
    release dut.r_frame_cnt;
    checks++;
    if (bus.oFrameCount !== 16'hFFFF) begin
      failures++;
      $display("FAIL wrap_preload got=%h exp=ffff", bus.oFrameCount);
    end
    for (int k = 0; k < 64; k++) begin
      step(1'b1, 1'b1, (k % 16) == 4);
      if (k == 48) begin
        checks++;
        if (bus.oFrameStart !== 1'b1 || bus.oResidualValid !== 1'b1) begin
          failures++;
          $display("FAIL wrap_frame_start got=%b%b exp=11", bus.oFrameStart, bus.oResidualValid);
        end
      end
      if (k == 62) begin
        checks++;
        if (bus.oFrameCount !== 16'hFFFF) begin
          failures++;
          $display("FAIL wrap_before got=%h exp=ffff", bus.oFrameCount);
        end
      end
      if (k == 63) begin
        checks++;
        if (bus.oFrameCount !== 16'h0000 || bus.oOverrun !== 1'b0) begin
          failures++;
          $display("FAIL wrap_after got=%h ov=%b exp=0000 ov=0", bus.oFrameCount, bus.oOverrun);
        end
      end
    end
  endtask

  initial begin
    bus.iEnable     = 1'b0;
    bus.iValid      = 1'b0;
    bus.iDurbinDone = 1'b0;
    test_reset();
    test_pipeline();
    test_overrun();
    test_enable_hold();
    test_async_reset();
    test_frame_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/compress_sequencer.md
# compress_sequencer

Frame-level scheduler for the compression datapath. It counts incoming samples into fixed-size blocks and generates the per-stage strobes for the three-deep block pipeline: autocorrelation, model solve, filter-bank selection, and residual output. Those strobes are the reset, enable, start, unload and valid signals for the ACF generator, Durbinator, filter bank, coefficient store and residual filter. It replaces the free-running tie-offs at the top level and reports model overruns.

## Interface
Parameters:
- BLOCK_SIZE, 4096: samples per block; power of two, at least 16.
- COPY_CYCLES, 12: cycles to copy the ACF into the Durbinator.
- MODEL_CYCLES, 1152: Durbin watchdog limit, in cycles.
- Constraint: COPY_CYCLES + MODEL_CYCLES < BLOCK_SIZE.

Ports:
- iClock  in  1  single clock, rising edge.
- iReset  in  1  asynchronous, active-high; clears all state.
- iEnable  in  1  global run; low freezes all state.
- iValid  in  1  one sample accepted per cycle when iValid & iEnable.
- iDurbinDone  in  1  model-solve complete pulse.
- oAcfReset  out  1  1-cycle pulse when the first sample of a block is accepted.
- oAcfEnable  out  1  registered copy of the accepted-sample strobe.
- oModelStart  out  1  1-cycle pulse at the start of COPY.
- oModelEnable  out  1  high during COPY and SOLVE.
- oBankReset  out  1  1-cycle pulse at a block boundary when the bank stage becomes valid.
- oBankValid  out  1  accepted sample that belongs to the bank-stage block.
- oCoeffUnload  out  1  1-cycle pulse at a block boundary when the residual stage becomes valid.
- oResidualValid  out  1  accepted sample that belongs to the residual-stage block.
- oFrameStart  out  1  with the first oResidualValid of a block.
- oFrameCount  out  16  count of completed residual blocks; wraps 0xFFFF→0.
- oOverrun  out  1  sticky flag; cleared only by iReset.

## Operation
- Accept strobe: acc = iValid & iEnable. Counter idx[log2(BLOCK_SIZE)-1:0] increments on acc and wraps BLOCK_SIZE-1 → 0.
- Block boundary: bnd = acc & (idx == BLOCK_SIZE-1).
- Model FSM states: IDLE, COPY, SOLVE, READY.
  - IDLE → COPY on bnd. Asserts oModelStart; the copy counter loads COPY_CYCLES-1.
  - COPY → SOLVE when the copy counter reaches 0.
  - SOLVE → READY on iDurbinDone.
  - READY → COPY on bnd. The stage tokens shift in the same cycle (see below).
  - bnd while in COPY or SOLVE: set oOverrun, restart at COPY for the new block, and clear the token passed to the bank stage.
- Stage tokens vB (bank) and vR (residual), updated on bnd only:
  - vB ← (state == READY).
  - vR ← vB.
  - oBankReset fires if the new vB is 1.
  - oCoeffUnload fires if the new vR is 1.
- oBankValid = acc & vB. oResidualValid = acc & vR. oFrameStart = acc & vR & (idx == 0).
- oFrameCount increments on bnd when vR is 1 (before the shift).
- iDurbinDone outside SOLVE is ignored.
- iEnable low: idx, FSM, the copy/watchdog counters and the tokens hold. All pulse outputs and valids are low.
- iReset (asynchronous, mid-operation included): idx = 0, FSM = IDLE, vB = vR = 0, oFrameCount = 0, oOverrun = 0, all outputs 0.

## Timing
- Every output is registered and trails its causing acc/state edge by exactly 1 cycle.
- Reset value of every output: 0.
- Earliest events from reset, with continuous iValid:
  - First oBankValid: sample 2·BLOCK_SIZE.
  - First oResidualValid: sample 3·BLOCK_SIZE.
- COPY lasts exactly COPY_CYCLES cycles. SOLVE lasts ≥1 cycle.
- Simultaneous bnd and iDurbinDone in SOLVE: counts as an overrun; iDurbinDone loses.
- oCoeffUnload leads the first oResidualValid of its block by ≥1 cycle; downstream load latency is absorbed by the data delay lines.

## Configuration
- SEQ_WATCHDOG_EN defined: a watchdog counter runs in SOLVE. Reaching MODEL_CYCLES without iDurbinDone sets oOverrun and moves the FSM to IDLE; that block's token is then 0.
- SEQ_WATCHDOG_EN undefined: no counter. SOLVE waits indefinitely and only a block boundary aborts it.

## Test plan
All scenarios use BLOCK_SIZE=16, COPY_CYCLES=2, MODEL_CYCLES=6.
- Reset, then 48 continuous samples with iDurbinDone 3 cycles after each COPY:
  - oAcfReset at samples 0, 16, 32.
  - oModelStart at samples 16 and 32.
  - oBankValid on samples 32–47.
  - oOverrun stays 0.
- Continue to 64 samples:
  - oCoeffUnload at the sample-48 boundary.
  - oResidualValid on samples 48–63; oFrameStart once.
  - oFrameCount = 1 after sample 63.
- iDurbinDone withheld, watchdog enabled:
  - oOverrun rises 6 cycles into SOLVE.
  - No oBankValid for the next block.
- iEnable low for 5 cycles mid-block: idx holds and no pulses occur; the resumed boundary lands 5 cycles late.
- iReset asserted mid-SOLVE: all outputs 0 asynchronously; after release, the first oAcfReset occurs on the first accepted sample.
- Force oFrameCount to 0xFFFF: the next residual block completion gives 0x0000.
